// File: rtl/tff_toggle_arb.sv
// Round-robin arbiter that grants one of four requesters a burst of toggle
// cycles on a shared T flip-flop, with a local model of the flop state.
module tff_toggle_arb #(
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*CNT_W-1:0]   cnt_in,
  input  logic                 abort,
  output logic [3:0]           gnt,
  output logic                 tog,
  output logic                 done,
  output logic                 busy,
  output logic                 q_exp,
  output logic [7:0]           tog_total
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TOGGLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               q_q;
  logic [7:0]         tot_q;

  logic [2:0]         pick;
  logic [CNT_W-1:0]   pick_cnt;

  // {found, index}: first requesting bit at or after p, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] j;
    res = 3'b000;
    for (int off = 3; off >= 0; off--) begin
      j = p + 2'(off);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_slice(input logic [4*CNT_W-1:0] c,
                                                 input logic [1:0] sel);
    logic [CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel == 2'(i)) v = c[i*CNT_W +: CNT_W];
    end
    return v;
  endfunction

  assign pick     = rr_pick(req, ptr_q);
  assign pick_cnt = cnt_slice(cnt_in, pick[1:0]);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick[2]) begin
          idx_d   = pick[1:0];
          gnt_d   = 4'b0001 << pick[1:0];
          rem_d   = pick_cnt;
          state_d = (pick_cnt != '0) ? S_TOGGLE : S_DONE;
        end
      end
      S_TOGGLE: begin
        rem_d = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
        // Abort wins over the final-count transition into DONE.
        if (abort) begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = idx_q + 2'd1;
          rem_d   = '0;
        end else if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        ptr_d   = idx_q + 2'd1;
        rem_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // Mirror of the shared flop and a wrapping count of toggle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= 1'b0;
      tot_q <= 8'd0;
    end else if (tog) begin
      q_q   <= ~q_q;
      tot_q <= tot_q + 8'd1;
    end
  end

  assign gnt       = gnt_q;
  assign tog       = (state_q == S_TOGGLE);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign q_exp     = q_q;
  assign tog_total = tot_q;

endmodule

// File: tb/tb_tff_toggle_arb.sv
// Scoreboard bench for tff_toggle_arb: directed services push expected
// service records, a negedge monitor rebuilds each service and compares.
module tb_tff_toggle_arb;
  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          req;
  logic [4*CNT_W-1:0]  cnt_in;
  logic                abort;
  logic [3:0]          gnt;
  logic                tog, done, busy, q_exp;
  logic [7:0]          tog_total;

  always #5 clk = ~clk;

  tff_toggle_arb #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .cnt_in(cnt_in), .abort(abort),
    .gnt(gnt), .tog(tog), .done(done), .busy(busy), .q_exp(q_exp),
    .tog_total(tog_total)
  );

  typedef struct {
    logic [3:0] gnt;
    int         ntog;
    int         dpos;
    int         len;
    int         gap;
    logic       q;
    logic [7:0] tot;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       model_q = 1'b0;
  logic [7:0] model_tot = 8'd0;
  bit         armed = 1'b0;
  bit         idle_bad = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [15:0] cnts(input logic [3:0] c0, input logic [3:0] c1,
                                       input logic [3:0] c2, input logic [3:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic expect_svc(input logic [3:0] g, input int ntog, input bit has_done,
                            input int gap, input bit rst_after);
    exp_t e;
    e.gnt  = g;
    e.ntog = ntog;
    e.dpos = has_done ? ntog : -1;
    e.len  = has_done ? ntog + 1 : ntog;
    e.gap  = gap;
    if (rst_after) begin
      model_q   = 1'b0;
      model_tot = 8'd0;
    end else begin
      model_tot = model_tot + 8'(ntog);
      model_q   = model_q ^ ntog[0];
    end
    e.q   = model_q;
    e.tot = model_tot;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_timeout", busy, 1);
  endtask

  // Present a request at the grant edge, then scramble the inputs: the
  // service must be immune to changes after the grant.
  task automatic issue(input logic [3:0] r, input logic [15:0] c, input bit ab);
    wait_idle();
    req    = r;
    cnt_in = c;
    abort  = ab;
    @(posedge clk); #1;
    abort  = 1'b0;
    req    = 4'b0000;
    cnt_in = 16'hFFFF;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q   = 1'b0;
    model_tot = 8'd0;
  endtask

  // Monitor
  bit         in_svc = 1'b0;
  int         pos, ntog_o, dpos_o, gap_o;
  int         idle_cnt = 0;
  logic [3:0] g_o;
  bit         bad;

  always @(negedge clk) begin
    if (in_svc && busy === 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_service: got gnt %b, expected no service", g_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("gnt", g_o, e.gnt);
        check("tog_cycles", ntog_o, e.ntog);
        check("done_pos", dpos_o, e.dpos);
        check("svc_len", pos, e.len);
        if (e.gap >= 0) check("idle_gap", gap_o, e.gap);
        check("protocol", bad, 0);
        check("q_exp", q_exp, e.q);
        check("tog_total", tog_total, e.tot);
      end
      in_svc   = 1'b0;
      idle_cnt = 1;
    end else if (busy === 1'b1) begin
      if (!in_svc) begin
        in_svc = 1'b1;
        pos    = 0;
        ntog_o = 0;
        dpos_o = -1;
        gap_o  = idle_cnt;
        g_o    = gnt;
        bad    = 1'b0;
      end
      if (gnt !== g_o || $countones(gnt) != 1) bad = 1'b1;
      if (tog === 1'b1 && done === 1'b1) bad = 1'b1;
      if (tog === 1'b1) begin
        if (ntog_o != pos) bad = 1'b1;
        ntog_o++;
      end
      if (done === 1'b1) begin
        if (dpos_o >= 0) bad = 1'b1;
        dpos_o = pos;
      end
      pos++;
    end else begin
      idle_cnt++;
      if (armed && (gnt !== 4'b0000 || tog !== 1'b0 || done !== 1'b0)) idle_bad = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    req    = 4'b0000;
    cnt_in = '0;
    abort  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;
    check("rst_gnt", gnt, 0);
    check("rst_tog", tog, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_q_exp", q_exp, 0);
    check("rst_tog_total", tog_total, 0);

    // Single requester, count 3
    expect_svc(4'b0001, 3, 1, -1, 0);
    issue(4'b0001, cnts(4'd3, 4'd0, 4'd0, 4'd0), 1'b0);
    check("lat_gnt", gnt, 4'b0001);
    check("lat_tog", tog, 1);
    wait_idle();
    check("req034_q_exp", q_exp, 1);
    check("req034_tog_total", tog_total, 3);

    // All requesters held, count 1: rotation with one idle cycle between
    do_reset(2);
    expect_svc(4'b0001, 1, 1, -1, 0);
    expect_svc(4'b0010, 1, 1, 1, 0);
    expect_svc(4'b0100, 1, 1, 1, 0);
    expect_svc(4'b1000, 1, 1, 1, 0);
    expect_svc(4'b0001, 1, 1, 1, 0);
    req    = 4'b1111;
    cnt_in = cnts(4'd1, 4'd1, 4'd1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      wait_busy();
      if (i == 4) req = 4'b0000;
      wait_idle();
    end

    // Zero count: straight to DONE, total unchanged
    expect_svc(4'b0100, 0, 1, -1, 0);
    issue(4'b0100, cnts(4'd15, 4'd15, 4'd0, 4'd15), 1'b0);
    wait_idle();
    check("zero_cnt_total", tog_total, 5);

    // Abort while idle is ignored
    expect_svc(4'b0010, 2, 1, -1, 0);
    issue(4'b0010, cnts(4'd0, 4'd2, 4'd0, 4'd0), 1'b1);

    // Abort on 2nd tog of count 5; next grant prefers requester 1
    expect_svc(4'b0001, 2, 0, -1, 0);
    issue(4'b0001, cnts(4'd5, 4'd0, 4'd0, 4'd0), 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_next", busy, 0);
    expect_svc(4'b0010, 2, 1, -1, 0);
    issue(4'b0011, cnts(4'd3, 4'd2, 4'd0, 4'd0), 1'b0);

    // Abort coinciding with the last tog cycle suppresses done
    expect_svc(4'b0100, 2, 0, -1, 0);
    issue(4'b0100, cnts(4'd0, 4'd0, 4'd2, 4'd0), 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;

    // Reset in 3rd tog cycle of count 8
    expect_svc(4'b0100, 3, 0, -1, 1);
    issue(4'b0100, cnts(4'd0, 4'd0, 4'd8, 4'd0), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_gnt", gnt, 0);
    check("midrst_tog", tog, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_q_exp", q_exp, 0);
    check("midrst_tog_total", tog_total, 0);
    expect_svc(4'b0100, 1, 1, -1, 0);
    issue(4'b1100, cnts(4'd0, 4'd0, 4'd1, 4'd1), 1'b0);
    expect_svc(4'b1000, 1, 1, -1, 0);
    issue(4'b1000, cnts(4'd0, 4'd0, 4'd0, 4'd1), 1'b0);

    // 256 toggles: counter wraps to 0, q_exp back to 0
    wait_idle();
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      expect_svc(4'b0001, 15, 1, -1, 0);
      issue(4'b0001, cnts(4'd15, 4'd0, 4'd0, 4'd0), 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      expect_svc(4'b0001, 1, 1, -1, 0);
      issue(4'b0001, cnts(4'd1, 4'd0, 4'd0, 4'd0), 1'b0);
    end
    wait_idle();
    check("wrap_tog_total", tog_total, 0);
    check("wrap_q_exp", q_exp, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    check("idle_outputs", idle_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tff_toggle_arb.md
TFF_TOGGLE_ARB -- requirements
Module: tff_toggle_arb

Interface
REQ-001 The module SHALL have parameter CNT_W, default 4, giving the per-requester toggle-count width.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The module SHALL have port req, input, 4 bits: toggle request, one bit per requester 0..3.
REQ-005 The module SHALL have port cnt_in, input, 4*CNT_W bits: requested toggle count; slice [i*CNT_W +: CNT_W] belongs to requester i.
REQ-006 The module SHALL have port abort, input, 1 bit: cancel the current service.
REQ-007 The module SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-008 The module SHALL have port tog, output, 1 bit: toggle enable that drives the shared T flip-flop's in_a input.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The module SHALL have port q_exp, output, 1 bit: expected T flip-flop state, toggled on every tog cycle.
REQ-012 The module SHALL have port tog_total, output, 8 bits: running count of tog cycles.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, TOGGLE and DONE; tog SHALL be 1 only in TOGGLE.
REQ-014 In IDLE with req != 0, the module SHALL select winner i by round-robin starting at pointer ptr (search ptr, ptr+1, ... mod 4).
REQ-015 On that edge the module SHALL set gnt to one-hot i and latch rem = cnt_in slice i.
REQ-016 On that edge, if the latched count is nonzero, the FSM SHALL go to TOGGLE.
REQ-017 On that edge, if the latched count is zero, the FSM SHALL go directly to DONE with no tog cycle.
REQ-018 In TOGGLE, rem SHALL decrement each cycle; when rem == 1 the FSM SHALL go to DONE, giving exactly N consecutive tog cycles for count N.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, gnt SHALL remain asserted, and ptr SHALL be set to (i+1) mod 4.
REQ-020 On the next edge after DONE, the FSM SHALL return to IDLE and gnt SHALL be 0.
REQ-021 Because of REQ-020, there SHALL be at least one IDLE cycle between services, even with req held.
REQ-022 Latency: with req sampled at edge k, gnt SHALL be high from cycle k+1, the first tog SHALL occur in cycle k+1, and done SHALL occur in cycle k+1+N.
REQ-023 Changes to req or cnt_in after the grant edge SHALL be ignored until the FSM returns to IDLE, including deassertion of the granted requester.
REQ-024 abort=1 in TOGGLE or DONE SHALL force IDLE on the next edge with gnt=0 and no done pulse, and ptr SHALL still advance to (i+1) mod 4.
REQ-025 abort in IDLE SHALL be ignored.
REQ-026 abort SHALL take priority over the REQ-018 transition to DONE when both occur in the same cycle.
REQ-027 q_exp SHALL invert on every edge where tog=1.
REQ-028 tog_total SHALL increment on every edge where tog=1 and SHALL wrap from 255 to 0.
REQ-029 gnt SHALL never have more than one bit set.
REQ-030 done and tog SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 at an edge SHALL force state IDLE, gnt=0, tog=0, done=0, busy=0, q_exp=0, tog_total=0, ptr=0 and rem=0, regardless of state.
REQ-032 Reset mid-TOGGLE SHALL truncate the service with no done pulse.
REQ-033 rst SHALL take priority over abort and req.

Verification
REQ-034 The bench SHALL cover: rst for 5 cycles, then req=0001 with cnt0=3 -> gnt=0001, then 3 tog cycles, then done in the 4th cycle, then q_exp=1 and tog_total=3.
REQ-035 The bench SHALL cover: req=1111 held with all counts 1 -> grants in order 0001, 0010, 0100, 1000, 0001, each followed by one idle cycle.
REQ-036 The bench SHALL cover: req=0100 with cnt2=0 -> gnt=0100 for one cycle, done=1 in that cycle, tog never 1, and tog_total unchanged.
REQ-037 The bench SHALL cover: cnt0=5 with abort on the 2nd tog cycle -> exactly 2 tog cycles, no done, IDLE next, and the following grant prefers requester 1.
REQ-038 The bench SHALL cover: rst asserted in the 3rd tog cycle of a count-8 service -> all outputs 0 on the next cycle, and the next req=1000 is granted with ptr=0 search order.
REQ-039 The bench SHALL cover: 256 total tog cycles (e.g. 16 services of count 15 plus 16 of count 1) -> tog_total wraps to 0 and q_exp=0.
